ren_simd_arbiter: RTL and testbench

- Shares one FP_SIMD instance (4 lanes x 22-bit, 3-bit opcode, en/valid/busy interface) among NUM_REQ requesters, e.g. fragment shader, rasterizer setup and blender.
- Grants one operation at a time using round-robin priority.
- Latches the winner's operands and opcode, issues them to the SIMD, and routes the result back to the winner only.
- Sits between the shader-stage FSMs and the FP_SIMD instance.

---
 rtl/ren_simd_arbiter.sv | 142 ++++++++++++++
 tb/tb_ren_simd_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ren_simd_arbiter.sv
// rtl/ren_simd_arbiter.sv - round-robin arbiter sharing one FP_SIMD among NUM_REQ requesters
module ren_simd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LANE_W  = 22,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [3*NUM_REQ-1:0]          i_opcode,
    input  logic [4*LANE_W*NUM_REQ-1:0]   i_in0,
    input  logic [4*LANE_W*NUM_REQ-1:0]   i_in1,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [4*LANE_W-1:0]           o_result,
    output logic [NUM_REQ-1:0]            o_result_valid,
    output logic                          o_busy,
    output logic                          o_err,
    output logic                          o_simd_en,
    output logic [2:0]                    o_simd_opcode,
    output logic [4*LANE_W-1:0]           o_simd_in0,
    output logic [4*LANE_W-1:0]           o_simd_in1,
    input  logic [4*LANE_W-1:0]           i_simd_out,
    input  logic                          i_simd_valid,
    input  logic                          i_simd_busy
);
    localparam int VW = 4 * LANE_W;
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, owner, sel_id, owner_next;
    logic                sel_found;
    logic [7:0]          wait_cnt, wait_cnt_inc;
    logic                timeout_hit;
    logic [NUM_REQ-1:0]  sel_onehot, owner_onehot;

    // Rotating search starting at ptr; idx is one bit wider so ptr+i never wraps early
    always_comb begin : rr_select
        logic [ID_W:0] idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!sel_found && i_req[idx[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_onehot           = '0;
        sel_onehot[sel_id]   = 1'b1;
        owner_onehot         = '0;
        owner_onehot[owner]  = 1'b1;
        owner_next           = (owner == LAST_ID) ? '0 : owner + 1'b1;
        wait_cnt_inc         = wait_cnt + 8'd1;
        timeout_hit          = (wait_cnt_inc == TO_LIM);
    end

    assign o_busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sel_found) state_nxt = S_ISSUE;
            S_ISSUE: if (!i_simd_busy) state_nxt = S_WAIT;
            S_WAIT:  if (i_simd_valid || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, issue and result strobes default low so each is a single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            owner          <= '0;
            wait_cnt       <= '0;
            o_gnt          <= '0;
            o_result       <= '0;
            o_result_valid <= '0;
            o_err          <= 1'b0;
            o_simd_en      <= 1'b0;
            o_simd_opcode  <= '0;
            o_simd_in0     <= '0;
            o_simd_in1     <= '0;
        end else begin
            o_gnt          <= '0;
            o_simd_en      <= 1'b0;
            o_result_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        owner         <= sel_id;
                        o_gnt         <= sel_onehot;
                        o_simd_opcode <= i_opcode[int'(sel_id)*3 +: 3];
                        o_simd_in0    <= i_in0[int'(sel_id)*VW +: VW];
                        o_simd_in1    <= i_in1[int'(sel_id)*VW +: VW];
                        wait_cnt      <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!i_simd_busy) begin
                        o_simd_en <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_simd_valid) begin
                        o_result       <= i_simd_out;
                        o_result_valid <= owner_onehot;
                        ptr            <= owner_next;
                        wait_cnt       <= '0;
                    end else if (timeout_hit) begin
                        o_err          <= 1'b1;
                        o_result       <= '0;
                        o_result_valid <= owner_onehot;
                        ptr            <= owner_next;
                        wait_cnt       <= '0;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ren_simd_arbiter.sv
// tb/tb_ren_simd_arbiter.sv - self-checking bench for ren_simd_arbiter
module tb_ren_simd_arbiter;
    localparam int N  = 4;
    localparam int LW = 22;
    localparam int VW = 4 * LW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    i_req;
    logic [3*N-1:0]  i_opcode;
    logic [VW*N-1:0] i_in0, i_in1;
    logic [N-1:0]    o_gnt, o_result_valid;
    logic [VW-1:0]   o_result, o_simd_in0, o_simd_in1;
    logic            o_busy, o_err, o_simd_en;
    logic [2:0]      o_simd_opcode;
    logic [VW-1:0]   i_simd_out;
    logic            i_simd_valid, i_simd_busy;

    logic            mvalid = 1'b0;
    logic            spur = 1'b0;
    logic [VW-1:0]   mout = '0;
    logic [VW-1:0]   mres = '0;
    int              lat = 1;
    int              mcnt = 0;
    bit              pend = 0;
    bit              hang = 0;

    assign i_simd_valid = mvalid | spur;
    assign i_simd_out   = mout;

    ren_simd_arbiter #(.NUM_REQ(N), .LANE_W(LW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_opcode(i_opcode),
        .i_in0(i_in0), .i_in1(i_in1), .o_gnt(o_gnt), .o_result(o_result),
        .o_result_valid(o_result_valid), .o_busy(o_busy), .o_err(o_err),
        .o_simd_en(o_simd_en), .o_simd_opcode(o_simd_opcode),
        .o_simd_in0(o_simd_in0), .o_simd_in1(o_simd_in1),
        .i_simd_out(i_simd_out), .i_simd_valid(i_simd_valid), .i_simd_busy(i_simd_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [VW-1:0] res;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        logic [2:0]   op;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        int           lat;
        logic [N-1:0] exp_gnt;
        int           exp_id;
    } vec_t;

    exp_t rq[$];
    int   gq[$];
    exp_t mon_e;
    int   mon_g;
    logic [N-1:0] mon_oh;

    function automatic logic [VW-1:0] calc(input logic [2:0] op, input logic [VW-1:0] x, input logic [VW-1:0] y);
        logic [LW-1:0] a, b, r;
        calc = '0;
        for (int l = 0; l < 4; l++) begin
            a = x[l*LW +: LW];
            b = y[l*LW +: LW];
            case (op)
                3'd0:    r = a + b;
                3'd1:    r = a - b;
                3'd2:    r = a ^ b;
                3'd3:    r = a & b;
                default: r = a | b;
            endcase
            calc[l*LW +: LW] = r;
        end
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [2:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b);
        i_opcode[3*k +: 3] = op;
        i_in0[k*VW +: VW]  = {4{a}};
        i_in1[k*VW +: VW]  = {4{b}};
    endtask

    task automatic expect_op(input int id, input logic [VW-1:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        gq.push_back(id);
        rq.push_back(e);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (rq.size() != 0 && n < max) begin
            step();
            n++;
        end
        chk("drain_results", rq.size(), 0);
        chk("drain_grants", gq.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_result", o_result, 0);
        chk("rst_rv", o_result_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        chk("rst_en", o_simd_en, 0);
        chk("rst_op", o_simd_opcode, 0);
        chk("rst_in0", o_simd_in0, 0);
        chk("rst_in1", o_simd_in1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        chk_reset_outputs();
        rst = 1'b0;
        step();
    endtask

    task automatic run_vec(input vec_t v);
        logic [2:0]    op;
        logic [LW-1:0] a, b;
        lat = v.lat;
        for (int k = 0; k < N; k++) begin
            load(k, v.op + 3'(k), v.a + LW'(k*256), v.b + LW'(k));
        end
        op = v.op + 3'(v.exp_id);
        a  = v.a + LW'(v.exp_id*256);
        b  = v.b + LW'(v.exp_id);
        expect_op(v.exp_id, calc(op, {4{a}}, {4{b}}));
        i_req = v.req;
        step();
        chk("vec_gnt", o_gnt, v.exp_gnt);
        i_req = '0;
        step();
        chk("vec_simd_en", o_simd_en, 1);
        wait_drain(300);
        chk("vec_busy_done", o_busy, 0);
    endtask

    // SIMD model: answers lat cycles after the issue strobe unless hung
    always @(negedge clk) begin
        if (rst) begin
            pend   = 0;
            mvalid = 1'b0;
        end else begin
            mvalid = 1'b0;
            if (pend) begin
                if (mcnt <= 1) begin
                    mvalid = 1'b1;
                    mout   = mres;
                    pend   = 0;
                end else begin
                    mcnt--;
                end
            end
            if (o_simd_en && !hang) begin
                pend = 1;
                mcnt = lat;
                mres = calc(o_simd_opcode, o_simd_in0, o_simd_in1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (o_gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", o_gnt, 0);
                end else begin
                    mon_g  = gq.pop_front();
                    mon_oh = 4'b0001 << mon_g;
                    chk("gnt_order", o_gnt, mon_oh);
                end
            end
            if (o_result_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("rv_unexpected", o_result_valid, 0);
                end else begin
                    mon_e  = rq.pop_front();
                    mon_oh = 4'b0001 << mon_e.id;
                    chk("rv_owner", o_result_valid, mon_oh);
                    chk("result", o_result, mon_e.res);
                end
            end
        end
    end

    vec_t vt[6];
    logic [VW-1:0] orig0, last_exp;
    int ng, n;

    initial begin
        vt[0] = '{4'b0001, 3'd1, 22'h0F0000, 22'h000123, 4, 4'b0001, 0};
        vt[1] = '{4'b0101, 3'd0, 22'h012345, 22'h0ABCDE, 1, 4'b0100, 2};
        vt[2] = '{4'b1001, 3'd2, 22'h3FFFFF, 22'h155555, 2, 4'b1000, 3};
        vt[3] = '{4'b0110, 3'd3, 22'h2F0F0F, 22'h1FF00F, 3, 4'b0010, 1};
        vt[4] = '{4'b0011, 3'd4, 22'h000001, 22'h200000, 6, 4'b0001, 0};
        vt[5] = '{4'b1010, 3'd1, 22'h000000, 22'h000001, 1, 4'b0010, 1};

        rst = 1'b1;
        i_req = '0;
        i_opcode = '0;
        i_in0 = '0;
        i_in1 = '0;
        i_simd_busy = 1'b0;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i]);
        end

        // busy stall with operands changing after grant
        lat = 2;
        load(1, 3'd2, 22'h2AAAAA, 22'h155555);
        orig0 = {4{22'h2AAAAA}};
        expect_op(1, calc(3'd2, orig0, {4{22'h155555}}));
        i_simd_busy = 1'b1;
        i_req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) begin
                chk("stall_gnt", o_gnt, 4'b0010);
                i_req = '0;
                load(1, 3'd7, 22'h000777, 22'h000999);
            end
            chk("stall_en_low", o_simd_en, 0);
        end
        i_simd_busy = 1'b0;
        step();
        chk("stall_en_pulse", o_simd_en, 1);
        chk("stall_in0_latched", o_simd_in0, orig0);
        chk("stall_op_latched", o_simd_opcode, 3'd2);
        step();
        chk("stall_en_once", o_simd_en, 0);
        wait_drain(100);

        // round robin with all requesters held
        do_reset();
        lat = 2;
        for (int k = 0; k < N; k++) begin
            load(k, 3'(k), LW'(22'h001000 * (k+1)), LW'(22'h000011 * (k+3)));
        end
        for (int j = 0; j < 8; j++) begin
            expect_op(j % N, calc(3'(j % N), {4{LW'(22'h001000 * (j%N+1))}}, {4{LW'(22'h000011 * (j%N+3))}}));
        end
        i_req = 4'b1111;
        ng = 0;
        n = 0;
        while (ng < 8 && n < 200) begin
            step();
            n++;
            if (o_gnt != '0) ng++;
        end
        i_req = '0;
        chk("rr_grant_count", ng, 8);
        wait_drain(100);

        // timeout with a request pending behind it
        hang = 1;
        lat = 3;
        load(0, 3'd0, 22'h000100, 22'h000200);
        expect_op(0, '0);
        i_req = 4'b0001;
        step();
        chk("to_gnt", o_gnt, 4'b0001);
        i_req = '0;
        step();
        chk("to_en", o_simd_en, 1);
        for (int i = 0; i < 250; i++) step();
        chk("to_err_early", o_err, 0);
        load(2, 3'd3, 22'h3C3C3C, 22'h0FFFF0);
        last_exp = calc(3'd3, {4{22'h3C3C3C}}, {4{22'h0FFFF0}});
        expect_op(2, last_exp);
        i_req = 4'b0100;
        n = 0;
        while (rq.size() == 2 && n < 50) begin
            step();
            n++;
        end
        chk("to_cycles", 250 + n, 255);
        chk("to_err_set", o_err, 1);
        hang = 0;
        step();
        chk("to_next_gnt", o_gnt, 4'b0100);
        i_req = '0;
        wait_drain(100);
        chk("to_err_sticky", o_err, 1);

        // reset mid-operation, then a valid arriving in IDLE
        lat = 20;
        load(0, 3'd0, 22'h000005, 22'h000006);
        gq.push_back(0);
        i_req = 4'b0001;
        step();
        i_req = '0;
        for (int i = 0; i < 4; i++) step();
        chk("midop_busy", o_busy, 1);
        rst = 1'b1;
        step();
        step();
        chk_reset_outputs();
        rst = 1'b0;
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        chk("midop_no_rv", o_result_valid, 0);
        chk("midop_result", o_result, 0);
        lat = 2;
        load(2, 3'd0, 22'h0A0A0A, 22'h050505);
        last_exp = calc(3'd0, {4{22'h0A0A0A}}, {4{22'h050505}});
        expect_op(2, last_exp);
        i_req = 4'b0100;
        step();
        chk("midop_gnt2", o_gnt, 4'b0100);
        i_req = '0;
        wait_drain(100);

        // spurious valid in IDLE
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_rv", o_result_valid, 0);
        step();
        chk("spur_result_hold", o_result, last_exp);
        chk("spur_busy", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
